// File: rtl/ram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_responder_pkg
//  Description : Shared constants and state encoding for the RAM responder.
//                DATALINES_DEF / ADLINES_DEF give the default word and
//                address widths of the control unit's RAM bus.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_responder_pkg;

   localparam int DATALINES_DEF = 16;
   localparam int ADLINES_DEF   = 8;

   // LOAD: program image streaming in, CPU held off.
   // RUN : CPU owns the RAM port until the next reset.
   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } resp_state_e;

endpackage : ram_responder_pkg
`default_nettype wire

// File: rtl/ram_responder_ram_core.sv
`default_nettype none
// ============================================================================
//  Module      : ram_core
//  Description : Single-port synchronous RAM, 2**AW words of DW bits.
//                Write on we; rdata is a register loaded from mem[addr]
//                when re is high and held otherwise. The array itself has
//                no reset; only the read register is cleared by rst.
//  Ports       : clk, rst (async, active-high, read register only)
//                we, re, addr[AW], wdata[DW] -> rdata[DW]
//  Revision    : 1.0  initial release
// ============================================================================
module ram_core #(
   parameter int DW = 16,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule : ram_core
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ram_responder
//  Description : Memory-side responder for the control unit's RAM bus.
//                After reset it accepts a program image on a valid/ready
//                stream (written from address 0 upward), then releases the
//                CPU via cpu_enable and serves its fetch/load/store requests.
//  Ports       : clk, rst               clock, async active-high reset
//                addressbus, read,      CPU request bus
//                write, toram
//                fromram                registered read data (latency 1)
//                load_valid, load_data, image stream in
//                load_last, load_ready
//                cpu_enable             control unit enable
//                bus_err                sticky: read and write together
//  Revision    : 1.0  initial release
// ============================================================================
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int datalines = DATALINES_DEF,
   parameter int adlines   = ADLINES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [adlines-1:0]   addressbus,
   input  logic                 read,
   input  logic                 write,
   input  logic [datalines-1:0] toram,
   output logic [datalines-1:0] fromram,
   input  logic                 load_valid,
   input  logic [datalines-1:0] load_data,
   input  logic                 load_last,
   output logic                 load_ready,
   output logic                 cpu_enable,
   output logic                 bus_err
);

   localparam logic [adlines-1:0] PTR_MAX = '1;
   localparam logic [adlines-1:0] PTR_ONE = {{(adlines-1){1'b0}}, 1'b1};

   resp_state_e          state_d, state_q;
   logic [adlines-1:0]   ptr_d, ptr_q;
   logic                 load_ready_d, load_ready_q;
   logic                 cpu_enable_d, cpu_enable_q;
   logic                 bus_err_d, bus_err_q;

   logic                 ram_we;
   logic                 ram_re;
   logic [adlines-1:0]   ram_addr;
   logic [datalines-1:0] ram_wdata;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      load_ready_d = load_ready_q;
      cpu_enable_d = cpu_enable_q;
      bus_err_d    = bus_err_q;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      ram_addr     = addressbus;
      ram_wdata    = toram;

      case (state_q)
         ST_LOAD: begin
            // load_ready comes up on the first edge after reset release.
            load_ready_d = 1'b1;
            cpu_enable_d = 1'b0;
            ram_addr     = ptr_q;
            ram_wdata    = load_data;
            if (load_valid && load_ready_q) begin
               ram_we = 1'b1;
               if (load_last || (ptr_q == PTR_MAX)) begin
                  state_d      = ST_RUN;
                  load_ready_d = 1'b0;
                  cpu_enable_d = 1'b1;
               end
               // A full-memory load parks the pointer instead of wrapping.
               if (ptr_q != PTR_MAX) begin
                  ptr_d = ptr_q + PTR_ONE;
               end
            end
         end
         ST_RUN: begin
            // Simultaneous read+write: the write wins, the read is dropped
            // so fromram holds, and the error is latched until reset.
            ram_we = write;
            ram_re = read & ~write;
            if (read && write) begin
               bus_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         ptr_q        <= '0;
         load_ready_q <= 1'b0;
         cpu_enable_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         load_ready_q <= load_ready_d;
         cpu_enable_q <= cpu_enable_d;
         bus_err_q    <= bus_err_d;
      end
   end

   ram_core #(
      .DW (datalines),
      .AW (adlines)
   ) u_ram_core (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (fromram)
   );

   assign load_ready = load_ready_q;
   assign cpu_enable = cpu_enable_q;
   assign bus_err    = bus_err_q;

endmodule : ram_responder
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_responder
//  Description : Self-checking bench for ram_responder. A plain array models
//                the memory; fromram / bus_err expectations follow from the
//                bus rules applied to that array.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_responder;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addressbus;
   logic          read;
   logic          write;
   logic [DW-1:0] toram;
   logic [DW-1:0] fromram;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_last;
   logic          load_ready;
   logic          cpu_enable;
   logic          bus_err;

   logic [DW-1:0] mem_m [DEPTH];
   logic [DW-1:0] exp_rd;
   logic          exp_err;
   int            errors = 0;
   int            checks = 0;

   ram_responder #(.datalines(DW), .adlines(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .addressbus (addressbus),
      .read       (read),
      .write      (write),
      .toram      (toram),
      .fromram    (fromram),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .cpu_enable (cpu_enable),
      .bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      exp_rd  = '0;
      exp_err = 1'b0;
      chk("rst_fromram", 32'(fromram), 32'(exp_rd));
      chk("rst_cpu_enable", 32'(cpu_enable), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_load_ready", 32'(load_ready), 32'd1);
      chk("post_rst_cpu_enable", 32'(cpu_enable), 32'd0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input string tag);
      read = 1'b1; write = 1'b0; addressbus = a;
      tick();
      read = 1'b0;
      exp_rd = mem_m[a];
      chk(tag, 32'(fromram), 32'(exp_rd));
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      read = 1'b0; write = 1'b1; addressbus = a; toram = d;
      tick();
      write = 1'b0;
      mem_m[a] = d;
   endtask

   initial begin
      logic [DW-1:0] image [4];
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      int            op;

      image[0] = 16'h0000; image[1] = 16'h1234;
      image[2] = 16'hBEEF; image[3] = 16'h0042;
      rst = 1'b1; read = 1'b0; write = 1'b0; addressbus = '0; toram = '0;
      load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      exp_rd = '0; exp_err = 1'b0;

      // Power-on reset.
      tick();
      do_reset();

      // Full-memory load without load_last: auto-transition after addr 255.
      for (int i = 0; i < DEPTH; i++) begin
         d = DW'($urandom);
         mem_m[i] = d;
         load_valid = 1'b1; load_data = d; load_last = 1'b0;
         if (i == 0 || i == DEPTH-1) begin
            chk("full_load_ready", 32'(load_ready), 32'd1);
            chk("full_load_cpu_off", 32'(cpu_enable), 32'd0);
         end
         tick();
      end
      chk("full_done_ready", 32'(load_ready), 32'd0);
      chk("full_done_cpu_en", 32'(cpu_enable), 32'd1);

      // Keep streaming in RUN: must be ignored (no wrap onto address 0).
      load_data = 16'hDEAD;
      tick(); tick(); tick();
      load_valid = 1'b0;
      chk("run_ignores_load_ready", 32'(load_ready), 32'd0);
      rd(8'd0, "nowrap_mem0");
      rd(8'd255, "full_mem255");
      for (int i = 0; i < 6; i++) begin
         rd(AW'($urandom), "full_rand_rd");
      end

      // Partial load of 2 words, then reset mid-load.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         d = DW'($urandom);
         mem_m[i] = d;
         load_valid = 1'b1; load_data = d; load_last = 1'b0;
         tick();
      end
      load_valid = 1'b0;
      chk("partial_cpu_off", 32'(cpu_enable), 32'd0);
      do_reset();

      // Reload the 4-word test image from word 0.
      for (int i = 0; i < 4; i++) begin
         mem_m[i] = image[i];
         load_valid = 1'b1; load_data = image[i]; load_last = (i == 3);
         chk("img_cpu_off", 32'(cpu_enable), 32'd0);
         tick();
      end
      load_valid = 1'b0; load_last = 1'b0;
      chk("img_done_ready", 32'(load_ready), 32'd0);
      chk("img_done_cpu_en", 32'(cpu_enable), 32'd1);
      for (int i = 0; i < 4; i++) begin
         rd(AW'(i), "img_rd");
      end
      rd(8'd4, "retain_mem4");
      rd(8'd100, "retain_mem100");
      rd(8'd255, "retain_mem255");

      // Read address 2, then idle: fromram holds.
      rd(8'd2, "rd_addr2");
      chk("rd_addr2_val", 32'(fromram), 32'h0000BEEF);
      tick(); tick();
      chk("idle_hold", 32'(fromram), 32'h0000BEEF);

      // Store then read-after-write.
      wr(8'h10, 16'h5A5A);
      chk("wr_fromram_hold", 32'(fromram), 32'h0000BEEF);
      rd(8'h10, "raw_0x10");
      chk("raw_0x10_val", 32'(fromram), 32'h00005A5A);
      chk("no_bus_err", 32'(bus_err), 32'd0);

      // Simultaneous read+write: write done, read dropped, error sticky.
      read = 1'b1; write = 1'b1; addressbus = 8'd3; toram = 16'h7777;
      tick();
      read = 1'b0; write = 1'b0;
      mem_m[3] = 16'h7777;
      exp_err  = 1'b1;
      chk("rw_fromram_hold", 32'(fromram), 32'h00005A5A);
      chk("rw_bus_err", 32'(bus_err), 32'(exp_err));
      rd(8'd3, "rw_mem3");
      chk("rw_mem3_val", 32'(fromram), 32'h00007777);
      chk("bus_err_sticky", 32'(bus_err), 32'(exp_err));

      // Random RUN traffic against the array model.
      for (int i = 0; i < 200; i++) begin
         op = int'($urandom_range(0, 2));
         a  = AW'($urandom);
         d  = DW'($urandom);
         read = (op == 1); write = (op == 2); addressbus = a; toram = d;
         tick();
         if (op == 1) exp_rd = mem_m[a];
         if (op == 2) mem_m[a] = d;
         chk("rand_fromram", 32'(fromram), 32'(exp_rd));
      end
      read = 1'b0; write = 1'b0;
      chk("rand_bus_err", 32'(bus_err), 32'(exp_err));
      chk("rand_cpu_en", 32'(cpu_enable), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ram_responder
`default_nettype wire
